// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus used by fetch_unit.
//   imem_req    : request valid; address held stable until imem_gnt
//   imem_addr   : 16-bit fetch address
//   imem_gnt    : memory accepts the request this cycle
//   imem_rvalid : read data valid (at least one cycle after grant)
//   imem_rdata  : 16-bit instruction word
// Modports: master = fetch side, slave = memory side.
interface fetch_unit_if;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [15:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, issues one outstanding request at a time to
// instruction memory and presents 16-bit instructions to decode. Honours decode stall and
// branch/jump redirect, and stops fetching after a HALT (opcode 5'b00000) is consumed.
//
// Ports:
//   clk          : clock
//   rst          : synchronous reset, active low
//   imem         : instruction-memory bus (fetch_unit_if.master)
//   id_stall     : decode cannot accept instr this cycle
//   redirect     : branch/jump taken; squash and refetch from redirect_pc
//   redirect_pc  : new fetch target
//   instr        : instruction to decode (16'h0800 NOP when !instr_valid)
//   instr_valid  : instr meaningful
//   pc_out       : address of instr
//   pc_plus2     : pc_out + 2 (link value for JAL/JALR)
//   halted       : fetch stopped after HALT
//
// Parameters: RESET_PC, and EXC_VECTOR (present only with FETCH_EXC_EN).
// Optional feature, macro FETCH_EXC_EN: consuming SIIC saves epc = pc + 2 and fetches from
// EXC_VECTOR; consuming RTI fetches from epc. Without it both are ordinary instructions.
module fetch_unit #(
`ifdef FETCH_EXC_EN
  parameter logic [15:0] EXC_VECTOR = 16'h0002,
`endif
  parameter logic [15:0] RESET_PC   = 16'h0000
) (
  input  logic               clk,
  input  logic               rst,
  fetch_unit_if.master       imem,
  input  logic               id_stall,
  input  logic               redirect,
  input  logic        [15:0] redirect_pc,
  output logic        [15:0] instr,
  output logic               instr_valid,
  output logic        [15:0] pc_out,
  output logic        [15:0] pc_plus2,
  output logic               halted
);

  localparam logic [15:0] InstrNop  = 16'h0800;
  localparam logic [4:0]  OpHalt    = 5'b00000;
`ifdef FETCH_EXC_EN
  localparam logic [4:0]  OpSiic    = 5'b00010;
  localparam logic [4:0]  OpRti     = 5'b00011;
`endif

  typedef enum logic [1:0] {
    StReq,
    StWait,
    StPresent,
    StHalted
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] instr_q, instr_d;
  logic        instr_valid_q, instr_valid_d;
  logic [15:0] pc_out_q, pc_out_d;
  logic [15:0] pc_plus2_q, pc_plus2_d;
  logic        halted_q, halted_d;
  logic        squash_q, squash_d;
`ifdef FETCH_EXC_EN
  logic [15:0] epc_q, epc_d;
`endif

  logic [4:0]  opcode;
  logic [15:0] pc_inc;

  assign opcode = instr_q[15:11];
  assign pc_inc = pc_q + 16'd2;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    pc_out_d      = pc_out_q;
    pc_plus2_d    = pc_plus2_q;
    halted_d      = halted_q;
    squash_d      = squash_q;
`ifdef FETCH_EXC_EN
    epc_d         = epc_q;
`endif

    if (redirect) begin
      pc_d          = redirect_pc;
      instr_d       = InstrNop;
      instr_valid_d = 1'b0;
      halted_d      = 1'b0;
      if (state_q == StWait) begin
        if (imem.imem_rvalid) begin
          // The in-flight response lands this very cycle: drop it and refetch now,
          // otherwise we would wait forever for a response that never comes.
          squash_d = 1'b0;
          state_d  = StReq;
        end else begin
          squash_d = 1'b1;
          state_d  = StWait;
        end
      end else if (state_q == StReq && imem.imem_gnt) begin
        // Request was accepted anyway; its response must be discarded.
        squash_d = 1'b1;
        state_d  = StWait;
      end else begin
        squash_d = 1'b0;
        state_d  = StReq;
      end
    end else begin
      unique case (state_q)
        StReq: begin
          if (imem.imem_gnt) begin
            state_d = StWait;
          end
        end
        StWait: begin
          if (imem.imem_rvalid) begin
            if (squash_q) begin
              squash_d = 1'b0;
              state_d  = StReq;
            end else begin
              instr_d       = imem.imem_rdata;
              instr_valid_d = 1'b1;
              pc_out_d      = pc_q;
              pc_plus2_d    = pc_inc;
              state_d       = StPresent;
            end
          end
        end
        StPresent: begin
          if (!id_stall) begin
            instr_d       = InstrNop;
            instr_valid_d = 1'b0;
            pc_d          = pc_inc;
            state_d       = StReq;
            if (opcode == OpHalt) begin
              halted_d = 1'b1;
              state_d  = StHalted;
            end
`ifdef FETCH_EXC_EN
            if (opcode == OpSiic) begin
              epc_d = pc_inc;
              pc_d  = EXC_VECTOR;
            end else if (opcode == OpRti) begin
              pc_d = epc_q;
            end
`endif
          end
        end
        StHalted: begin
          halted_d = 1'b1;
        end
        default: begin
          state_d = StReq;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= StReq;
      pc_q          <= RESET_PC;
      instr_q       <= InstrNop;
      instr_valid_q <= 1'b0;
      pc_out_q      <= RESET_PC;
      pc_plus2_q    <= RESET_PC + 16'd2;
      halted_q      <= 1'b0;
      squash_q      <= 1'b0;
`ifdef FETCH_EXC_EN
      epc_q         <= RESET_PC;
`endif
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      pc_out_q      <= pc_out_d;
      pc_plus2_q    <= pc_plus2_d;
      halted_q      <= halted_d;
      squash_q      <= squash_d;
`ifdef FETCH_EXC_EN
      epc_q         <= epc_d;
`endif
    end
  end

  // Request is decoded from state; suppressed while reset is asserted.
  assign imem.imem_req  = (state_q == StReq) && rst;
  assign imem.imem_addr = pc_q;

  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign pc_out      = pc_out_q;
  assign pc_plus2    = pc_plus2_q;
  assign halted      = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [15:0] instr;
  logic        instr_valid;
  logic [15:0] pc_out;
  logic [15:0] pc_plus2;
  logic        halted;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_unit_if imem_bus ();

  fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .imem        (imem_bus),
    .id_stall    (id_stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr       (instr),
    .instr_valid (instr_valid),
    .pc_out      (pc_out),
    .pc_plus2    (pc_plus2),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  // Memory model: words default to 16'h4000; response after mem_lat cycles.
  logic [15:0] mem [logic [15:0]];
  int          mem_lat = 1;
  int          pend_cnt = 0;
  logic [15:0] pend_addr = 16'h0000;

  function automatic logic [15:0] mem_rd(input logic [15:0] a);
    return mem.exists(a) ? mem[a] : 16'h4000;
  endfunction

  initial begin
    imem_bus.imem_rvalid = 1'b0;
    imem_bus.imem_rdata  = 16'h0000;
  end

  always @(posedge clk) begin
    imem_bus.imem_rvalid <= 1'b0;
    if (pend_cnt != 0) begin
      pend_cnt <= pend_cnt - 1;
      if (pend_cnt == 1) begin
        imem_bus.imem_rvalid <= 1'b1;
        imem_bus.imem_rdata  <= mem_rd(pend_addr);
      end
    end
    if (imem_bus.imem_req && imem_bus.imem_gnt) begin
      pend_addr <= imem_bus.imem_addr;
      if (mem_lat == 1) begin
        imem_bus.imem_rvalid <= 1'b1;
        imem_bus.imem_rdata  <= mem_rd(imem_bus.imem_addr);
      end else begin
        pend_cnt <= mem_lat - 1;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    id_stall = 1'b0;
    redirect = 1'b0;
    redirect_pc = 16'h0000;
    imem_bus.imem_gnt = 1'b1;
    step();
    step();
    // Reset state
    check_eq("rst_req", imem_bus.imem_req, 1'b0);
    check_eq("rst_valid", instr_valid, 1'b0);
    check_eq("rst_instr", instr, 16'h0800);
    check_eq("rst_pc_out", pc_out, 16'h0000);
    check_eq("rst_pc_plus2", pc_plus2, 16'h0002);
    check_eq("rst_halted", halted, 1'b0);

    // Stream: one instruction every 3 cycles, addresses 0,2,4
    rst = 1'b1;
    #1;
    check_eq("c1_req", imem_bus.imem_req, 1'b1);
    check_eq("c1_addr", imem_bus.imem_addr, 16'h0000);
    step();
    check_eq("c2_valid", instr_valid, 1'b0);
    check_eq("c2_req", imem_bus.imem_req, 1'b0);
    step();
    check_eq("c3_valid", instr_valid, 1'b1);
    check_eq("c3_instr", instr, 16'h4000);
    check_eq("c3_pc_out", pc_out, 16'h0000);
    check_eq("c3_pc_plus2", pc_plus2, 16'h0002);
    step();
    check_eq("c4_addr", imem_bus.imem_addr, 16'h0002);
    check_eq("c4_valid", instr_valid, 1'b0);
    step();
    step();
    check_eq("i2_pc_out", pc_out, 16'h0002);
    step();
    step();
    step();
    check_eq("i3_pc_out", pc_out, 16'h0004);
    check_eq("i3_pc_plus2", pc_plus2, 16'h0006);

    // Decode stall holds a presented 16'hD800
    mem[16'h0006] = 16'hD800;
    step();
    step();
    step();
    check_eq("st_instr0", instr, 16'hD800);
    id_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq("st_instr", instr, 16'hD800);
      check_eq("st_pc_out", pc_out, 16'h0006);
      check_eq("st_req", imem_bus.imem_req, 1'b0);
      check_eq("st_valid", instr_valid, 1'b1);
    end
    id_stall = 1'b0;
    step();
    check_eq("st_rel_req", imem_bus.imem_req, 1'b1);
    check_eq("st_rel_addr", imem_bus.imem_addr, 16'h0008);

    // Redirect while WAIT: in-flight response dropped
    mem_lat = 2;
    step();
    redirect = 1'b1;
    redirect_pc = 16'h0040;
    step();
    redirect = 1'b0;
    check_eq("rw_req", imem_bus.imem_req, 1'b0);
    check_eq("rw_valid", instr_valid, 1'b0);
    step();
    check_eq("rw_drop_valid", instr_valid, 1'b0);
    check_eq("rw_req2", imem_bus.imem_req, 1'b1);
    check_eq("rw_addr", imem_bus.imem_addr, 16'h0040);
    mem_lat = 1;
    step();
    step();
    check_eq("rw_pc_out", pc_out, 16'h0040);
    check_eq("rw_valid2", instr_valid, 1'b1);

    // Redirect beats consumption; then HALT at 16'h0010
    mem[16'h0010] = 16'h0000;
    redirect = 1'b1;
    redirect_pc = 16'h0010;
    step();
    redirect = 1'b0;
    check_eq("rp_addr", imem_bus.imem_addr, 16'h0010);
    check_eq("rp_valid", instr_valid, 1'b0);
    step();
    step();
    check_eq("h_instr", instr, 16'h0000);
    check_eq("h_pc_out", pc_out, 16'h0010);
    step();
    check_eq("h_halted", halted, 1'b1);
    check_eq("h_valid", instr_valid, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("h_req", imem_bus.imem_req, 1'b0);
      check_eq("h_halted_hold", halted, 1'b1);
    end
    redirect = 1'b1;
    redirect_pc = 16'h0020;
    step();
    redirect = 1'b0;
    check_eq("hr_halted", halted, 1'b0);
    check_eq("hr_req", imem_bus.imem_req, 1'b1);
    check_eq("hr_addr", imem_bus.imem_addr, 16'h0020);
    step();
    step();
    check_eq("hr_pc_out", pc_out, 16'h0020);

    // PC wrap at 16'hFFFE
    redirect = 1'b1;
    redirect_pc = 16'hFFFE;
    step();
    redirect = 1'b0;
    check_eq("w_addr", imem_bus.imem_addr, 16'hFFFE);
    step();
    step();
    check_eq("w_pc_out", pc_out, 16'hFFFE);
    check_eq("w_pc_plus2", pc_plus2, 16'h0000);
    step();
    check_eq("w_next_addr", imem_bus.imem_addr, 16'h0000);

    // Redirect in REQ with grant: request issued, response squashed; then SIIC at 16'h0030
    mem[16'h0030] = 16'h1000;
    mem[16'h0002] = 16'h1800;
    redirect = 1'b1;
    redirect_pc = 16'h0030;
    step();
    redirect = 1'b0;
    check_eq("rg_req", imem_bus.imem_req, 1'b0);
    step();
    check_eq("rg_valid", instr_valid, 1'b0);
    check_eq("rg_addr", imem_bus.imem_addr, 16'h0030);
    check_eq("rg_req2", imem_bus.imem_req, 1'b1);
    step();
    step();
    check_eq("si_instr", instr, 16'h1000);
    check_eq("si_pc_out", pc_out, 16'h0030);
    step();
`ifdef FETCH_EXC_EN
    check_eq("si_next_addr", imem_bus.imem_addr, 16'h0002);
    step();
    step();
    check_eq("rti_instr", instr, 16'h1800);
    check_eq("rti_pc_out", pc_out, 16'h0002);
    step();
    check_eq("rti_next_addr", imem_bus.imem_addr, 16'h0032);
`else
    check_eq("si_next_addr", imem_bus.imem_addr, 16'h0032);
`endif

    // Reset mid-WAIT; late response arrives in REQ and is ignored
    mem_lat = 3;
    step();
    rst = 1'b0;
    step();
    check_eq("mr_req", imem_bus.imem_req, 1'b0);
    check_eq("mr_valid", instr_valid, 1'b0);
    check_eq("mr_pc_out", pc_out, 16'h0000);
    rst = 1'b1;
    imem_bus.imem_gnt = 1'b0;
    step();
    check_eq("mr_late_rvalid", imem_bus.imem_rvalid, 1'b1);
    check_eq("mr_req2", imem_bus.imem_req, 1'b1);
    check_eq("mr_addr", imem_bus.imem_addr, 16'h0000);
    step();
    check_eq("mr_ignored_valid", instr_valid, 1'b0);
    check_eq("mr_req3", imem_bus.imem_req, 1'b1);
    mem_lat = 1;
    imem_bus.imem_gnt = 1'b1;
    step();
    step();
    check_eq("mr_fetch_valid", instr_valid, 1'b1);
    check_eq("mr_fetch_instr", instr, 16'h4000);
    check_eq("mr_fetch_pc", pc_out, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
